// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus, captures and holds SRAM read data across
// stalls, aligns/extends load data and drives the WB and forwarding buses.
module mem_stage #(
   parameter int EX_TO_MEM_WD = 81,
   parameter int MEM_TO_WB_WD = 70,
   parameter int STALL_W      = 6
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic [STALL_W-1:0]      stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [31:0]             data_sram_rdata,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [37:0]             mem_to_rf_bus,
   output logic                    mem_adel
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FRESH = 2'd1,
      ST_HELD  = 2'd2
   } rd_state_t;

   logic [EX_TO_MEM_WD-1:0] r_bus;
   rd_state_t               r_state;
   logic [31:0]             r_rdata_hold;

   logic w_mem_stall;
   logic w_wb_stall;
   logic w_in_is_load;
   logic w_unused;

   assign w_mem_stall  = stall[3];
   assign w_wb_stall   = stall[4];
   assign w_in_is_load = ex_to_mem_bus[43] & (|ex_to_mem_bus[80:76]);
   assign w_unused     = &{1'b0, stall[STALL_W-1:5], stall[2:0]};

   // A new load entering MEM always restarts capture, whatever the previous state was.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_bus        <= '0;
         r_state      <= ST_EMPTY;
         r_rdata_hold <= '0;
      end else if (!w_mem_stall) begin
         r_bus   <= ex_to_mem_bus;
         r_state <= w_in_is_load ? ST_FRESH : ST_EMPTY;
      end else if (!w_wb_stall) begin
         r_bus   <= '0;
         r_state <= ST_EMPTY;
      end else begin
         case (r_state)
            ST_FRESH: begin
               r_state      <= ST_HELD;
               r_rdata_hold <= data_sram_rdata;
            end
            default: r_state <= r_state;
         endcase
      end
   end

   logic [4:0]  w_mem_op;
   logic [31:0] w_pc;
   logic        w_sram_en;
   logic [3:0]  w_ram_wen;
   logic        w_sel_rf_res;
   logic        w_rf_we_in;
   logic [4:0]  w_rf_waddr;
   logic [31:0] w_ex_result;
   logic [1:0]  w_addr_lo;

   assign w_mem_op     = r_bus[80:76];
   assign w_pc         = r_bus[75:44];
   assign w_sram_en    = r_bus[43];
   assign w_ram_wen    = r_bus[42:39];
   assign w_sel_rf_res = r_bus[38];
   assign w_rf_we_in   = r_bus[37];
   assign w_rf_waddr   = r_bus[36:32];
   assign w_ex_result  = r_bus[31:0];
   assign w_addr_lo    = w_ex_result[1:0];

   logic w_op_lb, w_op_lbu, w_op_lh, w_op_lhu, w_op_lw;
   assign {w_op_lb, w_op_lbu, w_op_lh, w_op_lhu, w_op_lw} = w_mem_op;

   logic [31:0] w_load_raw;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load_data;

   always_comb begin
      w_load_raw = '0;
      case (r_state)
         ST_FRESH: w_load_raw = data_sram_rdata;
         ST_HELD:  w_load_raw = r_rdata_hold;
         default:  w_load_raw = '0;
      endcase
   end

   always_comb begin
      w_byte = '0;
      case (w_addr_lo)
         2'd0:    w_byte = w_load_raw[7:0];
         2'd1:    w_byte = w_load_raw[15:8];
         2'd2:    w_byte = w_load_raw[23:16];
         default: w_byte = w_load_raw[31:24];
      endcase
   end

   // Misaligned halfwords still pick by a[1]; the exception flag reports the fault.
   assign w_half = w_addr_lo[1] ? w_load_raw[31:16] : w_load_raw[15:0];

   always_comb begin
      w_load_data = '0;
      if (w_op_lb)       w_load_data = {{24{w_byte[7]}}, w_byte};
      else if (w_op_lbu) w_load_data = {24'd0, w_byte};
      else if (w_op_lh)  w_load_data = {{16{w_half[15]}}, w_half};
      else if (w_op_lhu) w_load_data = {16'd0, w_half};
      else if (w_op_lw)  w_load_data = w_load_raw;
   end

   logic        w_is_store;
   logic        w_rf_we;
   logic [31:0] w_rf_wdata;

   assign w_is_store = w_sram_en & (|w_ram_wen);
   assign w_rf_we    = w_rf_we_in & ~w_is_store;
   assign w_rf_wdata = w_sel_rf_res ? w_load_data : w_ex_result;

   assign mem_to_wb_bus = {w_pc, w_rf_we, w_rf_waddr, w_rf_wdata};
   assign mem_to_rf_bus = {w_rf_we, w_rf_waddr, w_rf_wdata};
   assign mem_adel      = ((w_op_lh | w_op_lhu) & w_addr_lo[0]) |
                          (w_op_lw & (w_addr_lo != 2'd0));

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, load alignment, stall hold, bubbles and forwarding.
`timescale 1ns/1ps
module tb_mem_stage;

   localparam logic [4:0] OP_LB  = 5'b10000;
   localparam logic [4:0] OP_LBU = 5'b01000;
   localparam logic [4:0] OP_LH  = 5'b00100;
   localparam logic [4:0] OP_LHU = 5'b00010;
   localparam logic [4:0] OP_LW  = 5'b00001;

   logic        clk;
   logic        resetn;
   logic [5:0]  stall;
   logic [80:0] ex_to_mem_bus;
   logic [31:0] data_sram_rdata;
   logic [69:0] mem_to_wb_bus;
   logic [37:0] mem_to_rf_bus;
   logic        mem_adel;

   int checks = 0;
   int errors = 0;

   mem_stage dut (
      .clk             (clk),
      .resetn          (resetn),
      .stall           (stall),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .data_sram_rdata (data_sram_rdata),
      .mem_to_wb_bus   (mem_to_wb_bus),
      .mem_to_rf_bus   (mem_to_rf_bus),
      .mem_adel        (mem_adel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [80:0] mk_bus(input logic [4:0] op, input logic [31:0] pc,
                                          input logic en, input logic [3:0] wen,
                                          input logic sel, input logic we,
                                          input logic [4:0] wa, input logic [31:0] res);
      return {op, pc, en, wen, sel, we, wa, res};
   endfunction

   function automatic logic [69:0] mk_wb(input logic [31:0] pc, input logic we,
                                         input logic [4:0] wa, input logic [31:0] d);
      return {pc, we, wa, d};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one load in EX, moves it into MEM and drives its read data.
   task automatic issue_load(input logic [4:0] op, input logic [31:0] pc,
                             input logic [4:0] wa, input logic [31:0] addr,
                             input logic [31:0] rdata);
      ex_to_mem_bus = mk_bus(op, pc, 1'b1, 4'd0, 1'b1, 1'b1, wa, addr);
      step();
      ex_to_mem_bus   = '0;
      data_sram_rdata = rdata;
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn          = 1'b0;
      stall           = '0;
      data_sram_rdata = 32'h5555_AAAA;
      ex_to_mem_bus   = mk_bus(OP_LW, 32'hBFC0_0000, 1'b1, 4'd0, 1'b1, 1'b1, 5'd9, 32'h0000_0001);
      step();
      step();
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus !== 70'd0 || mem_adel !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold wb=%h adel=%b want 0/0", mem_to_wb_bus, mem_adel);
      end
      resetn        = 1'b1;
      ex_to_mem_bus = '0;
      step();
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus !== 70'd0 || mem_to_rf_bus !== 38'd0 || mem_adel !== 1'b0) begin
         errors++;
         $display("FAIL reset_release wb=%h rf=%h adel=%b want 0", mem_to_wb_bus, mem_to_rf_bus, mem_adel);
      end
      $display("reset: wb=%h rf=%h adel=%b", mem_to_wb_bus, mem_to_rf_bus, mem_adel);
   endtask

   task automatic test_byte_loads();
      issue_load(OP_LB, 32'h0000_0100, 5'd3, 32'h0000_1003, 32'h80FF_1234);
      checks++;
      if (mem_to_wb_bus !== mk_wb(32'h0000_0100, 1'b1, 5'd3, 32'hFFFF_FF80) || mem_adel !== 1'b0) begin
         errors++;
         $display("FAIL lb_sign wb=%h adel=%b want %h/0", mem_to_wb_bus, mem_adel,
                  mk_wb(32'h0000_0100, 1'b1, 5'd3, 32'hFFFF_FF80));
      end
      $display("lb  @1003 -> %h", mem_to_wb_bus[31:0]);
      issue_load(OP_LBU, 32'h0000_0104, 5'd4, 32'h0000_1003, 32'h80FF_1234);
      checks++;
      if (mem_to_wb_bus[31:0] !== 32'h0000_0080) begin
         errors++;
         $display("FAIL lbu_zero got=%h want 00000080", mem_to_wb_bus[31:0]);
      end
      $display("lbu @1003 -> %h", mem_to_wb_bus[31:0]);
      issue_load(OP_LB, 32'h0000_0108, 5'd4, 32'h0000_1001, 32'h80FF_1234);
      checks++;
      if (mem_to_wb_bus[31:0] !== 32'h0000_0012) begin
         errors++;
         $display("FAIL lb_byte1 got=%h want 00000012", mem_to_wb_bus[31:0]);
      end
      $display("lb  @1001 -> %h", mem_to_wb_bus[31:0]);
   endtask

   task automatic test_half_loads();
      issue_load(OP_LH, 32'h0000_0200, 5'd6, 32'h0000_2002, 32'hBEEF_0001);
      checks++;
      if (mem_to_wb_bus[31:0] !== 32'hFFFF_BEEF || mem_adel !== 1'b0) begin
         errors++;
         $display("FAIL lh_hi got=%h adel=%b want ffffbeef/0", mem_to_wb_bus[31:0], mem_adel);
      end
      $display("lh  @2002 -> %h", mem_to_wb_bus[31:0]);
      issue_load(OP_LHU, 32'h0000_0204, 5'd6, 32'h0000_2002, 32'hBEEF_0001);
      checks++;
      if (mem_to_wb_bus[31:0] !== 32'h0000_BEEF) begin
         errors++;
         $display("FAIL lhu_hi got=%h want 0000beef", mem_to_wb_bus[31:0]);
      end
      $display("lhu @2002 -> %h", mem_to_wb_bus[31:0]);
      issue_load(OP_LH, 32'h0000_0208, 5'd6, 32'h0000_2001, 32'hBEEF_0001);
      checks++;
      if (mem_adel !== 1'b1 || mem_to_wb_bus[31:0] !== 32'h0000_0001) begin
         errors++;
         $display("FAIL lh_misalign adel=%b data=%h want 1/00000001", mem_adel, mem_to_wb_bus[31:0]);
      end
      $display("lh  @2001 -> adel=%b", mem_adel);
      issue_load(OP_LW, 32'h0000_020C, 5'd7, 32'h0000_2002, 32'hCAFE_F00D);
      checks++;
      if (mem_adel !== 1'b1 || mem_to_wb_bus[31:0] !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL lw_misalign adel=%b data=%h want 1/cafef00d", mem_adel, mem_to_wb_bus[31:0]);
      end
      $display("lw  @2002 -> adel=%b", mem_adel);
   endtask

   task automatic test_stall_hold();
      ex_to_mem_bus = mk_bus(OP_LW, 32'h0000_0300, 1'b1, 4'd0, 1'b1, 1'b1, 5'd8, 32'h0000_3000);
      step();
      ex_to_mem_bus   = '0;
      data_sram_rdata = 32'h1234_5678;
      stall           = 6'b011000;
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus !== mk_wb(32'h0000_0300, 1'b1, 5'd8, 32'h1234_5678)) begin
         errors++;
         $display("FAIL lw_fresh wb=%h want %h", mem_to_wb_bus, mk_wb(32'h0000_0300, 1'b1, 5'd8, 32'h1234_5678));
      end
      for (int i = 0; i < 3; i++) begin
         step();
         data_sram_rdata = 32'hDEAD_BEEF;
         @(negedge clk);
         checks++;
         if (mem_to_wb_bus !== mk_wb(32'h0000_0300, 1'b1, 5'd8, 32'h1234_5678)) begin
            errors++;
            $display("FAIL lw_held[%0d] wb=%h want %h", i, mem_to_wb_bus,
                     mk_wb(32'h0000_0300, 1'b1, 5'd8, 32'h1234_5678));
         end
         $display("hold cycle %0d -> %h", i, mem_to_wb_bus[31:0]);
      end
      step();
      stall = '0;
      step();
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus !== 70'd0) begin
         errors++;
         $display("FAIL post_hold_empty wb=%h want 0", mem_to_wb_bus);
      end
   endtask

   task automatic test_bubble_forward();
      ex_to_mem_bus = mk_bus(5'd0, 32'h0000_0400, 1'b0, 4'd0, 1'b0, 1'b1, 5'd5, 32'd7);
      step();
      ex_to_mem_bus = '0;
      @(negedge clk);
      checks++;
      if (mem_to_rf_bus !== {1'b1, 5'd5, 32'd7} || mem_to_wb_bus[69:38] !== 32'h0000_0400) begin
         errors++;
         $display("FAIL add_forward rf=%h pc=%h want %h/00000400", mem_to_rf_bus, mem_to_wb_bus[69:38],
                  {1'b1, 5'd5, 32'd7});
      end
      $display("add -> rf=%h", mem_to_rf_bus);
      stall = 6'b011000;
      step();
      @(negedge clk);
      checks++;
      if (mem_to_rf_bus !== {1'b1, 5'd5, 32'd7}) begin
         errors++;
         $display("FAIL add_stall_hold rf=%h want %h", mem_to_rf_bus, {1'b1, 5'd5, 32'd7});
      end
      stall = 6'b001000;
      step();
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus !== 70'd0 || mem_to_rf_bus[37] !== 1'b0) begin
         errors++;
         $display("FAIL bubble wb=%h want 0", mem_to_wb_bus);
      end
      $display("bubble -> wb=%h", mem_to_wb_bus);
      stall = '0;
      ex_to_mem_bus = mk_bus(5'd0, 32'h0000_0410, 1'b1, 4'b0001, 1'b0, 1'b1, 5'd2, 32'h0000_5000);
      step();
      ex_to_mem_bus = '0;
      @(negedge clk);
      checks++;
      if (mem_to_rf_bus[37] !== 1'b0) begin
         errors++;
         $display("FAIL store_no_we rf_we=%b want 0", mem_to_rf_bus[37]);
      end
   endtask

   task automatic test_reset_in_hold();
      ex_to_mem_bus = mk_bus(OP_LW, 32'h0000_0500, 1'b1, 4'd0, 1'b1, 1'b1, 5'd10, 32'h0000_4000);
      step();
      ex_to_mem_bus   = '0;
      data_sram_rdata = 32'hAAAA_5555;
      stall           = 6'b011000;
      step();
      data_sram_rdata = 32'h0101_0101;
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus[31:0] !== 32'hAAAA_5555) begin
         errors++;
         $display("FAIL held_before_reset got=%h want aaaa5555", mem_to_wb_bus[31:0]);
      end
      resetn = 1'b0;
      step();
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus !== 70'd0 || mem_to_rf_bus !== 38'd0 || mem_adel !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_hold wb=%h rf=%h want 0", mem_to_wb_bus, mem_to_rf_bus);
      end
      $display("reset in hold -> wb=%h", mem_to_wb_bus);
      resetn = 1'b1;
      stall  = '0;
      issue_load(OP_LW, 32'h0000_0504, 5'd11, 32'h0000_4004, 32'h0BAD_F00D);
      checks++;
      if (mem_to_wb_bus !== mk_wb(32'h0000_0504, 1'b1, 5'd11, 32'h0BAD_F00D)) begin
         errors++;
         $display("FAIL lw_after_reset wb=%h want %h", mem_to_wb_bus,
                  mk_wb(32'h0000_0504, 1'b1, 5'd11, 32'h0BAD_F00D));
      end
      $display("lw after reset -> %h", mem_to_wb_bus[31:0]);
   endtask

   task automatic test_back_to_back();
      ex_to_mem_bus = mk_bus(OP_LHU, 32'h0000_0600, 1'b1, 4'd0, 1'b1, 1'b1, 5'd12, 32'h0000_6000);
      step();
      ex_to_mem_bus   = mk_bus(OP_LB, 32'h0000_0604, 1'b1, 4'd0, 1'b1, 1'b1, 5'd13, 32'h0000_6002);
      data_sram_rdata = 32'h1111_F00F;
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus[31:0] !== 32'h0000_F00F) begin
         errors++;
         $display("FAIL b2b_lhu got=%h want 0000f00f", mem_to_wb_bus[31:0]);
      end
      $display("b2b lhu -> %h", mem_to_wb_bus[31:0]);
      step();
      ex_to_mem_bus   = '0;
      data_sram_rdata = 32'h33C4_2211;
      @(negedge clk);
      checks++;
      if (mem_to_wb_bus !== mk_wb(32'h0000_0604, 1'b1, 5'd13, 32'hFFFF_FFC4)) begin
         errors++;
         $display("FAIL b2b_lb wb=%h want %h", mem_to_wb_bus, mk_wb(32'h0000_0604, 1'b1, 5'd13, 32'hFFFF_FFC4));
      end
      $display("b2b lb  -> %h", mem_to_wb_bus[31:0]);
   endtask

   initial begin
      resetn          = 1'b0;
      stall           = '0;
      ex_to_mem_bus   = '0;
      data_sram_rdata = '0;
      test_reset();
      test_byte_loads();
      test_half_loads();
      test_stall_hold();
      test_bubble_forward();
      test_reset_in_hold();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
